// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin selection function for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Widest requester vector supported; callers zero-extend into it.
    localparam int unsigned RR_REQ_W = 8;
    localparam int unsigned RR_IDX_W = $clog2(RR_REQ_W);

    // First set bit scanning last+1, last+2, ... modulo n; 0 when nothing is set.
    function automatic logic [RR_IDX_W-1:0] next_rr(
        input logic [RR_REQ_W-1:0] req,
        input logic [RR_IDX_W-1:0] last,
        input int unsigned         n
    );
        logic [RR_IDX_W-1:0] win;
        logic                found;
        int unsigned         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_REQ_W; k++) begin
            idx = (32'(last) + k) % n;
            if (k <= n && !found && req[idx[RR_IDX_W-1:0]]) begin
                win   = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates priority to start just after last_grant.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    always_comb begin
        winner  = ID_W'(next_rr(RR_REQ_W'(req), RR_IDX_W'(last_grant), NUM_REQ));
        any_req = |req;
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// granting bursts of up to MAX_BURST words with one idle cycle between grants.
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;

    arb_state_e       state;
    logic [ID_W-1:0]  last_grant;
    logic [CNT_W-1:0] burst_cnt;
    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             wr_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Write path is combinational so the FIFO sees the strobe in the same cycle as full.
    always_comb begin
        wr_en        = (state == GRANT) && req[grant_id] && !fifo_full && !rst;
        fifo_write   = wr_en;
        req_ack      = '0;
        fifo_data_in = '0;
        if (wr_en) begin
            req_ack[grant_id] = 1'b1;
        end
        if (state == GRANT) begin
            fifo_data_in = req_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id    <= winner;
                        burst_cnt   <= '0;
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        last_grant  <= grant_id;
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (!fifo_full) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                        if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                            last_grant  <= grant_id;
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
